// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 8-bit ALU: accepts 16-bit instructions, reads a 4x8
// register file, drives registered ALU ports, retires results. Option macro: ALU_ISSUE_CMP_EN.
module alu_issue_ctrl #(
  parameter int NREGS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [3:0]  alu_operation,
  output logic [7:0]  alu_operand1,
  output logic [7:0]  alu_operand2,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  input  logic        alu_negative,
  output logic        done,
  output logic        illegal,
  output logic [7:0]  result_out,
  output logic [3:0]  status,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  // state | meaning
  // IDLE  | ready for an instruction; ALU ports hold last values
  // EXEC  | ALU ports stable; result and flags sampled at the end of the cycle
  // DONE  | done (and illegal if pending) pulse for one cycle

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_SHL = 4'h2;
  localparam logic [3:0] OP_SHR = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;

`ifdef ALU_ISSUE_CMP_EN
  localparam logic CMP_EN = 1'b1;
`else
  localparam logic CMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_nx;

  logic [7:0] regs [NREGS];
  logic [1:0] rd_q;
  logic       cmp_q;
  logic       illegal_q;
  logic       accept;
  logic       capture;
  logic       op_legal;
  logic       wb_en;

  logic [3:0] in_op;
  logic [1:0] in_rd;
  logic       in_imm_sel;
  logic       in_cmp;
  logic [7:0] in_imm8;
  logic [1:0] in_rs;

  assign in_op      = in_instr[15:12];
  assign in_rd      = in_instr[11:10];
  assign in_imm_sel = in_instr[9];
  assign in_cmp     = in_instr[8];
  assign in_imm8    = in_instr[7:0];
  assign in_rs      = in_instr[1:0];

  always_comb begin
    op_legal = 1'b0;
    case (alu_operation)
      OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // Compare form keeps flags and result but skips the register write.
  assign wb_en = capture & op_legal & ~(CMP_EN & cmp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        capture  = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        illegal  = illegal_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operands are latched on accept so later in_instr activity never reaches the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_operation <= 4'h0;
      alu_operand1  <= 8'h00;
      alu_operand2  <= 8'h00;
      rd_q          <= 2'd0;
      cmp_q         <= 1'b0;
      illegal_q     <= 1'b0;
      result_out    <= 8'h00;
      status        <= 4'h0;
    end else begin
      if (accept) begin
        alu_operation <= in_op;
        alu_operand1  <= regs[in_rd];
        alu_operand2  <= in_imm_sel ? in_imm8 : regs[in_rs];
        rd_q          <= in_rd;
        cmp_q         <= in_cmp;
      end
      if (capture) begin
        illegal_q <= ~op_legal;
        if (op_legal) begin
          status     <= {alu_zero, alu_overflow, alu_carry, alu_negative};
          result_out <= alu_result;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en && (rd_q == 2'(i))) regs[i] <= alu_result;
      end
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule
